// File: rtl/smi_axi_write_burst_ctrl_if.sv
// Bundles the request, aligner, AXI and completion channels of the SMI-to-AXI write burst controller.
// The master modport is the controller's view; slave is the surrounding environment.
interface smi_axi_write_burst_ctrl_if #(
  parameter int FlitWidth = 16,
  parameter int AddrWidth = 64
);
  logic                   reqReady;
  logic [AddrWidth-1:0]   reqAddr;
  logic [15:0]            reqLength;
  logic                   reqStop;

  logic                   alignSetupReady;
  logic [7:0]             alignByteOffset;
  logic                   alignSetupStop;

  logic                   wInReady;
  logic [FlitWidth*8-1:0] wInData;
  logic [FlitWidth-1:0]   wInStrobes;
  logic                   wInLast;
  logic                   wInStop;

  logic                   awValid;
  logic [AddrWidth-1:0]   awAddr;
  logic [7:0]             awLen;
  logic                   awReady;

  logic                   wValid;
  logic [FlitWidth*8-1:0] wData;
  logic [FlitWidth-1:0]   wStrb;
  logic                   wLast;
  logic                   wReady;

  logic                   bValid;
  logic [1:0]             bResp;
  logic                   bReady;

  logic                   doneReady;
  logic                   doneOk;
  logic                   doneStop;

  modport master (
    input  reqReady, reqAddr, reqLength,
    output reqStop,
    output alignSetupReady, alignByteOffset,
    input  alignSetupStop,
    input  wInReady, wInData, wInStrobes, wInLast,
    output wInStop,
    output awValid, awAddr, awLen,
    input  awReady,
    output wValid, wData, wStrb, wLast,
    input  wReady,
    input  bValid, bResp,
    output bReady,
    output doneReady, doneOk,
    input  doneStop
  );

  modport slave (
    output reqReady, reqAddr, reqLength,
    input  reqStop,
    input  alignSetupReady, alignByteOffset,
    output alignSetupStop,
    output wInReady, wInData, wInStrobes, wInLast,
    input  wInStop,
    input  awValid, awAddr, awLen,
    output awReady,
    input  wValid, wData, wStrb, wLast,
    output wReady,
    output bValid, bResp,
    input  bReady,
    input  doneReady, doneOk,
    output doneStop
  );
endinterface

// File: rtl/smi_axi_write_burst_ctrl.sv
// Sequences one SMI memory write onto AXI: aligner setup, 4 KiB / max-length burst split,
// zero-latency W forwarding with per-burst WLAST, B collection and a single completion status.
module smi_axi_write_burst_ctrl #(
  parameter int FlitWidth   = 16,
  parameter int AddrWidth   = 64,
  parameter int MaxBurstLen = 64
) (
  input  logic                      clk,
  input  logic                      srst,
  smi_axi_write_burst_ctrl_if.master bus
);
  localparam int OffW = $clog2(FlitWidth);
  localparam int QD   = 4;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [AddrWidth-1:0] r_burst_addr;
  logic [16:0]          r_remaining;
  logic [16:0]          r_total_beats;
  logic [16:0]          r_w_sent;
  logic [16:0]          r_b_out;
  logic [7:0]           r_offset;
  logic                 r_resp_err;
  logic                 r_frame_err;
  logic [8:0]           r_q [QD];
  logic [1:0]           r_q_wr;
  logic [1:0]           r_q_rd;
  logic [2:0]           r_q_cnt;
  logic [8:0]           r_beat_cnt;

  logic                 w_req_fire;
  logic [7:0]           w_req_off;
  logic [16:0]          w_req_sum;
  logic [16:0]          w_req_beats;
  logic [12:0]          w_page_room;
  logic [16:0]          w_page_beats;
  logic [16:0]          w_beats;
  logic                 w_aw_valid;
  logic                 w_aw_fire;
  logic                 w_q_empty;
  logic [8:0]           w_head;
  logic                 w_w_valid;
  logic                 w_w_fire;
  logic                 w_w_last;
  logic                 w_pop;
  logic                 w_final;
  logic                 w_b_fire;
  logic                 w_drained;

  // Request decode: byte offset, flit count and flit-aligned start address.
  assign w_req_fire  = (r_state == S_IDLE) && bus.reqReady;
  assign w_req_off   = 8'(bus.reqAddr[OffW-1:0]);
  assign w_req_sum   = 17'(w_req_off) + 17'(bus.reqLength) + 17'(FlitWidth - 1);
  assign w_req_beats = w_req_sum >> OffW;

  // Burst size is the smallest of what is left, the max burst and the room to the 4 KiB page end.
  assign w_page_room  = 13'd4096 - {1'b0, r_burst_addr[11:0]};
  assign w_page_beats = 17'(w_page_room >> OffW);
  always_comb begin
    w_beats = r_remaining;
    if (w_page_beats < w_beats)      w_beats = w_page_beats;
    if (17'(MaxBurstLen) < w_beats)  w_beats = 17'(MaxBurstLen);
  end

  assign w_aw_valid = (r_state == S_ISSUE) && (r_remaining != 17'd0) && (r_q_cnt != 3'(QD));
  assign w_aw_fire  = w_aw_valid && bus.awReady;

  // W path is pure forwarding gated by a burst being queued; the queue head sets WLAST.
  assign w_q_empty = (r_q_cnt == 3'd0);
  assign w_head    = r_q[r_q_rd];
  assign w_w_valid = bus.wInReady && !w_q_empty;
  assign w_w_fire  = w_w_valid && bus.wReady;
  assign w_w_last  = !w_q_empty && (r_beat_cnt == w_head - 9'd1);
  assign w_pop     = w_w_fire && w_w_last;
  assign w_final   = (r_w_sent == r_total_beats - 17'd1);

  assign w_b_fire  = bus.bValid && bus.bReady;
  assign w_drained = w_q_empty && (r_b_out == 17'd0) && (r_w_sent == r_total_beats);

  always_ff @(posedge clk) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.reqReady) w_next = (bus.reqLength == 16'd0) ? S_DONE : S_SETUP;
      S_SETUP: if (!bus.alignSetupStop) w_next = S_ISSUE;
      S_ISSUE: if ((r_remaining == 17'd0) || (w_aw_fire && (r_remaining == w_beats)))
                 w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = S_DONE;
      S_DONE:  if (!bus.doneStop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.reqStop         = (r_state != S_IDLE);
    bus.alignSetupReady = (r_state == S_SETUP);
    bus.alignByteOffset = r_offset;
    bus.awValid         = w_aw_valid;
    bus.awAddr          = r_burst_addr;
    bus.awLen           = 8'(w_beats - 17'd1);
    bus.doneReady       = (r_state == S_DONE);
    bus.doneOk          = !(r_resp_err || r_frame_err);
  end

  assign bus.wValid  = w_w_valid;
  assign bus.wData   = bus.wInData;
  assign bus.wStrb   = bus.wInStrobes;
  assign bus.wLast   = w_w_last;
  assign bus.wInStop = !w_w_fire;
  assign bus.bReady  = (r_b_out != 17'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_burst_addr  <= '0;
      r_remaining   <= '0;
      r_total_beats <= '0;
      r_w_sent      <= '0;
      r_b_out       <= '0;
      r_offset      <= '0;
      r_resp_err    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_q_wr        <= '0;
      r_q_rd        <= '0;
      r_q_cnt       <= '0;
      r_beat_cnt    <= '0;
    end else begin
      // Flags are cleared at acceptance so a zero-length request also reports clean status.
      if (w_req_fire) begin
        r_burst_addr  <= {bus.reqAddr[AddrWidth-1:OffW], {OffW{1'b0}}};
        r_remaining   <= (bus.reqLength == 16'd0) ? 17'd0 : w_req_beats;
        r_total_beats <= (bus.reqLength == 16'd0) ? 17'd0 : w_req_beats;
        r_offset      <= w_req_off;
        r_w_sent      <= '0;
        r_resp_err    <= 1'b0;
        r_frame_err   <= 1'b0;
      end

      if (w_aw_fire) begin
        r_burst_addr <= r_burst_addr + (AddrWidth'(w_beats) << OffW);
        r_remaining  <= r_remaining - w_beats;
        r_q[r_q_wr]  <= 9'(w_beats);
        r_q_wr       <= r_q_wr + 2'd1;
      end
      if (w_pop) r_q_rd <= r_q_rd + 2'd1;
      case ({w_aw_fire, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 3'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 3'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase

      if (w_w_fire) begin
        r_beat_cnt <= w_w_last ? 9'd0 : r_beat_cnt + 9'd1;
        r_w_sent   <= r_w_sent + 17'd1;
        if (bus.wInLast != w_final) r_frame_err <= 1'b1;
      end

      case ({w_aw_fire, w_b_fire})
        2'b10:   r_b_out <= r_b_out + 17'd1;
        2'b01:   r_b_out <= r_b_out - 17'd1;
        default: r_b_out <= r_b_out;
      endcase
      if (w_b_fire && (bus.bResp != 2'b00)) r_resp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_smi_axi_write_burst_ctrl.sv
// Randomized bench for smi_axi_write_burst_ctrl: a per-request burst plan is computed arithmetically
// and every AW/W/B/done handshake is compared against it.
module tb_smi_axi_write_burst_ctrl;
  localparam int FW  = 16;
  localparam int AW  = 64;
  localparam int MBL = 4;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  smi_axi_write_burst_ctrl_if #(.FlitWidth(FW), .AddrWidth(AW)) bus ();

  smi_axi_write_burst_ctrl #(.FlitWidth(FW), .AddrWidth(AW), .MaxBurstLen(MBL)) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.reqReady       = 1'b0;
    bus.reqAddr        = '0;
    bus.reqLength      = '0;
    bus.alignSetupStop = 1'b0;
    bus.wInReady       = 1'b0;
    bus.wInData        = '0;
    bus.wInStrobes     = '0;
    bus.wInLast        = 1'b0;
    bus.awReady        = 1'b0;
    bus.wReady         = 1'b0;
    bus.bValid         = 1'b0;
    bus.bResp          = 2'b00;
    bus.doneStop       = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_reqStop"},   bus.reqStop,         1'b0);
    check({tag, "_setupRdy"},  bus.alignSetupReady, 1'b0);
    check({tag, "_awValid"},   bus.awValid,         1'b0);
    check({tag, "_wValid"},    bus.wValid,          1'b0);
    check({tag, "_wLast"},     bus.wLast,           1'b0);
    check({tag, "_bReady"},    bus.bReady,          1'b0);
    check({tag, "_doneReady"}, bus.doneReady,       1'b0);
    check({tag, "_wInStop"},   bus.wInStop,         1'b1);
  endtask

  // lastAt: beat index on which wInLast is driven; errMask bit n marks burst n's response as SLVERR.
  task automatic run_xfer(input logic [63:0] addr, input int len, input int lastAt,
                          input logic [63:0] errMask, input int hold, input bit abort);
    logic [63:0] ba[$];
    int          bl[$];
    logic [63:0] a;
    logic [127:0] dat;
    logic [FW-1:0] strb;
    int off, total, rem, room, b, nb;
    bit exp_ok;
    int aw_i, wb, wbeat, w_sent, b_i, req_cyc, setup_cyc, lastb_cyc;
    bit req_acc, setup_done, finished, exp_wv;

    off   = int'(addr % FW);
    total = (len == 0) ? 0 : (off + len + FW - 1) / FW;
    a     = addr - 64'(off);
    rem   = total;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / FW;
      b    = rem;
      if (b > MBL)  b = MBL;
      if (b > room) b = room;
      ba.push_back(a);
      bl.push_back(b);
      a   = a + 64'(b * FW);
      rem = rem - b;
    end
    nb     = bl.size();
    exp_ok = (lastAt == total - 1) && ((errMask & ((64'd1 << nb) - 64'd1)) == 64'd0);

    aw_i = 0; wb = 0; wbeat = 0; w_sent = 0; b_i = 0;
    req_cyc = -10; setup_cyc = -10; lastb_cyc = -10;
    req_acc = 0; setup_done = 0; finished = 0;

    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      dat  = {$urandom, $urandom, $urandom, $urandom};
      strb = FW'($urandom);
      bus.reqReady       = !req_acc;
      bus.reqAddr        = addr;
      bus.reqLength      = 16'(len);
      bus.alignSetupStop = ($urandom_range(0, 2) == 0);
      bus.awReady        = ($urandom_range(0, 3) != 0);
      bus.wReady         = (c < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.wInReady       = (w_sent < total) && ($urandom_range(0, 3) != 0);
      bus.wInData        = dat;
      bus.wInStrobes     = strb;
      bus.wInLast        = (w_sent == lastAt);
      bus.bValid         = !abort && (b_i < wb) && ($urandom_range(0, 2) != 0);
      bus.bResp          = errMask[b_i % 64] ? 2'b10 : 2'b00;
      bus.doneStop       = ($urandom_range(0, 2) == 0);
      #1;

      if (!req_acc) check("req_stop", bus.reqStop, 1'b0);
      if (req_acc && c == req_cyc + 1) begin
        if (len == 0) check("done_zero", bus.doneReady, 1'b1);
        else          check("setup_rise", bus.alignSetupReady, 1'b1);
      end
      if (bus.alignSetupReady && !bus.alignSetupStop) begin
        check("offset", bus.alignByteOffset, 128'(off));
        setup_done = 1;
        setup_cyc  = c;
      end
      if (setup_done && c == setup_cyc + 1) check("aw_rise", bus.awValid, 1'b1);

      check("b_ready", bus.bReady, aw_i > b_i);
      exp_wv = bus.wInReady && (wb < aw_i);
      check("w_valid", bus.wValid, exp_wv);
      check("w_in_stop", bus.wInStop, !(exp_wv && bus.wReady));

      if (bus.awValid) begin
        if (aw_i >= nb) check("aw_extra", 1'b1, 1'b0);
        else begin
          check("q_depth", (aw_i - wb) < 4, 1'b1);
          if (bus.awReady) begin
            check("aw_addr", bus.awAddr, ba[aw_i]);
            check("aw_len", bus.awLen, 128'(bl[aw_i] - 1));
            aw_i++;
          end
        end
      end

      if (exp_wv) begin
        check("w_data", bus.wData, dat);
        check("w_strb", bus.wStrb, strb);
        if (bus.wReady && wb < nb) begin
          check("w_last", bus.wLast, wbeat == bl[wb] - 1);
          w_sent++;
          wbeat++;
          if (wbeat == bl[wb]) begin
            wb++;
            wbeat = 0;
          end
        end
      end

      if (bus.bValid && bus.bReady) begin
        b_i++;
        if (b_i == nb) lastb_cyc = c;
      end
      if (c == lastb_cyc + 1) check("done_early", bus.doneReady, 1'b0);
      if (c == lastb_cyc + 2) check("done_rise", bus.doneReady, 1'b1);

      if (hold > 0 && c == hold - 1) check("q_full_stall", aw_i, 4);

      if (bus.doneReady && !bus.doneStop) begin
        check("done_ok", bus.doneOk, exp_ok);
        check("n_bursts", aw_i, nb);
        check("n_beats", w_sent, total);
        finished = 1;
      end

      if (bus.reqReady && !bus.reqStop) begin
        req_acc = 1;
        req_cyc = c;
      end

      if (abort && total > 0 && w_sent == total && aw_i == nb) begin
        @(negedge clk);
        idle_inputs();
        bus.wInReady = 1'b1;
        srst = 1'b1;
        @(posedge clk);
        #1;
        reset_check("abort");
        @(negedge clk);
        srst = 1'b0;
        finished = 1;
      end
    end
    if (!finished) check("timeout", 1'b0, 1'b1);
  endtask

  function automatic int beats_of(input logic [63:0] addr, input int len);
    return (len == 0) ? 0 : (int'(addr % FW) + len + FW - 1) / FW;
  endfunction

  initial begin
    logic [63:0] addr;
    int len, tot, last;
    logic [63:0] em;

    idle_inputs();
    bus.wInReady = 1'b1;
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");
    @(negedge clk);
    idle_inputs();
    srst = 1'b0;

    run_xfer(64'h1000, 64, 3, 64'd0, 0, 0);
    run_xfer(64'h0FF8, 32, 2, 64'd0, 0, 0);
    run_xfer(64'h2000, 160, 9, 64'd0, 0, 0);
    run_xfer(64'h3000, 512, 31, 64'd0, 40, 0);
    run_xfer(64'h0FF8, 32, 2, 64'b10, 0, 0);
    run_xfer(64'h4000, 48, 2, 64'd0, 0, 0);
    run_xfer(64'h0100, 48, 1, 64'd0, 0, 0);
    run_xfer(64'h5004, 0, -1, 64'd0, 0, 0);
    run_xfer(64'h6000, 64, 3, 64'd0, 0, 1);
    run_xfer(64'h6000, 64, 3, 64'd0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      addr = {16'h0, 16'($urandom), $urandom};
      if ($urandom_range(0, 1) == 1) addr[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      len  = $urandom_range(1, 400);
      tot  = beats_of(addr, len);
      last = ($urandom_range(0, 5) == 0) ? $urandom_range(0, tot) : tot - 1;
      em   = ($urandom_range(0, 5) == 0) ? 64'($urandom) : 64'd0;
      run_xfer(addr, len, last, em, 0, 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
